// File: rtl/mem_bus_arbiter.sv
// Single-beat memory bus arbiter for the IF and MEM pipeline ports.
// The data port always wins a simultaneous request. Every grant ends either
// with a slave ack or with a wait-state timeout abort. stall_o holds the
// pipeline while a requester is waiting.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_sel,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ack,
  output logic        d_err,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [5:0]  stall_o
);

  typedef enum logic [1:0] {IDLE, GRANT_D, GRANT_IF} state_t;

  // Last wait-state cycle of a grant; the abort fires here, so the 8-bit
  // counter never wraps.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic        stb_nxt, we_nxt;
  logic [3:0]  sel_nxt;
  logic [31:0] addr_nxt, wdata_nxt;
  logic        if_ack_nxt, if_err_nxt, d_ack_nxt, d_err_nxt;
  logic [31:0] if_rdata_nxt, d_rdata_nxt;
  logic        d_go, if_go;

  // Next-state and next registered bus/port values.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    stb_nxt      = bus_stb;
    we_nxt       = bus_we;
    sel_nxt      = bus_sel;
    addr_nxt     = bus_addr;
    wdata_nxt    = bus_wdata;
    if_ack_nxt   = 1'b0;
    if_err_nxt   = 1'b0;
    d_ack_nxt    = 1'b0;
    d_err_nxt    = 1'b0;
    if_rdata_nxt = if_rdata;
    d_rdata_nxt  = d_rdata;
    // A port still holding its request during its own ack pulse is not
    // reissued.
    d_go         = d_req & ~d_ack;
    if_go        = if_req & ~if_ack;

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (d_go) begin
          state_nxt = GRANT_D;
          stb_nxt   = 1'b1;
          we_nxt    = d_we;
          sel_nxt   = d_sel;
          addr_nxt  = d_addr;
          wdata_nxt = d_wdata;
        end else if (if_go) begin
          state_nxt = GRANT_IF;
          stb_nxt   = 1'b1;
          we_nxt    = 1'b0;
          sel_nxt   = '1;
          addr_nxt  = if_addr;
        end
      end
      GRANT_D, GRANT_IF: begin
        if (bus_ack || cnt == CNT_LAST) begin
          state_nxt = IDLE;
          stb_nxt   = 1'b0;
          we_nxt    = 1'b0;
          cnt_nxt   = '0;
          if (state == GRANT_D) begin
            d_ack_nxt = 1'b1;
            d_err_nxt = ~bus_ack;
            if (!bus_ack)
              d_rdata_nxt = '0;
            else if (!bus_we)
              d_rdata_nxt = bus_rdata;
          end else begin
            if_ack_nxt   = 1'b1;
            if_err_nxt   = ~bus_ack;
            if_rdata_nxt = bus_ack ? bus_rdata : '0;
          end
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bus_stb   <= 1'b0;
      bus_we    <= 1'b0;
      bus_sel   <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      if_ack    <= 1'b0;
      if_err    <= 1'b0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bus_stb   <= stb_nxt;
      bus_we    <= we_nxt;
      bus_sel   <= sel_nxt;
      bus_addr  <= addr_nxt;
      bus_wdata <= wdata_nxt;
      if_ack    <= if_ack_nxt;
      if_err    <= if_err_nxt;
      d_ack     <= d_ack_nxt;
      d_err     <= d_err_nxt;
      if_rdata  <= if_rdata_nxt;
      d_rdata   <= d_rdata_nxt;
    end
  end

  // Pipeline stall: a waiting load/store freezes up to MEM, a waiting fetch up to ID.
  always_comb begin
    stall_o = '0;
    if (d_req && !d_ack)
      stall_o = 6'b011111;
    else if (if_req && !if_ack)
      stall_o = 6'b000111;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed vector table, multi-cycle corner
// sequences and randomized traffic against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int unsigned TO = 4;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ack, if_err;
  logic        d_req = 1'b0, d_we = 1'b0;
  logic [3:0]  d_sel = '0;
  logic [31:0] d_addr = '0, d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ack, d_err;
  logic        bus_stb, bus_we;
  logic [3:0]  bus_sel;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack;
  logic [5:0]  stall_o;

  int checks = 0;
  int failures = 0;

  mem_bus_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
    .d_req(d_req), .d_we(d_we), .d_sel(d_sel), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
    .bus_stb(bus_stb), .bus_we(bus_we), .bus_sel(bus_sel), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .stall_o(stall_o)
  );

  always #5 clk = ~clk;

  // Slave memory contents.
  function automatic logic [31:0] slave_data(input logic [31:0] a);
    if (a == 32'h10) return 32'h3401_1100;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  // Slave: acks after slave_wait wait states (never if >= TO).
  int unsigned slave_wait = 0;
  int unsigned age = 0;
  always @(posedge clk) age <= (bus_stb && !bus_ack) ? age + 1 : 0;
  assign bus_ack   = bus_stb && (age == slave_wait);
  assign bus_rdata = slave_data(bus_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per cycle, what the bus and ports must show given the
  // previous cycle's requests and the slave's wait setting.
  logic        e_stb = 0, e_we = 0;
  logic [3:0]  e_sel = '0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_if_rdata = '0, e_d_rdata = '0;
  logic        e_if_ack = 0, e_if_err = 0, e_d_ack = 0, e_d_err = 0;
  logic [5:0]  e_stall;
  int          e_own = 0;
  int unsigned e_age = 0;
  logic        p_rst = 1'b1, p_if_req = 0, p_d_req = 0, p_d_we = 0;
  logic [3:0]  p_d_sel = '0;
  logic [31:0] p_if_addr = '0, p_d_addr = '0, p_d_wdata = '0;
  int unsigned p_wait = 0;

  always @(negedge clk) begin : model
    logic oia, oda, hit;
    if (p_rst) begin
      e_stb = 0; e_we = 0; e_sel = '0; e_addr = '0; e_wdata = '0; e_own = 0; e_age = 0;
      e_if_ack = 0; e_if_err = 0; e_d_ack = 0; e_d_err = 0; e_if_rdata = '0; e_d_rdata = '0;
    end else begin
      oia = e_if_ack;
      oda = e_d_ack;
      e_if_ack = 0; e_if_err = 0; e_d_ack = 0; e_d_err = 0;
      if (e_stb) begin
        hit = (e_age == p_wait);
        if (hit || e_age == TO - 1) begin
          if (e_own == 1) begin
            e_d_ack = 1; e_d_err = !hit;
            if (!hit) e_d_rdata = '0;
            else if (!e_we) e_d_rdata = slave_data(e_addr);
          end else begin
            e_if_ack = 1; e_if_err = !hit;
            e_if_rdata = hit ? slave_data(e_addr) : '0;
          end
          e_stb = 0; e_we = 0; e_own = 0;
        end else begin
          e_age++;
        end
      end else if (p_d_req && !oda) begin
        e_stb = 1; e_own = 1; e_age = 0;
        e_we = p_d_we; e_sel = p_d_sel; e_addr = p_d_addr; e_wdata = p_d_wdata;
      end else if (p_if_req && !oia) begin
        e_stb = 1; e_own = 2; e_age = 0;
        e_we = 0; e_sel = 4'hF; e_addr = p_if_addr;
      end
    end
    e_stall = (d_req && !e_d_ack) ? 6'b011111 : (if_req && !e_if_ack) ? 6'b000111 : 6'b000000;
    chk("mon_stb", bus_stb, e_stb);
    chk("mon_we", bus_we, e_we);
    chk("mon_sel", bus_sel, e_sel);
    chk("mon_addr", bus_addr, e_addr);
    chk("mon_wdata", bus_wdata, e_wdata);
    chk("mon_if_ack", if_ack, e_if_ack);
    chk("mon_if_err", if_err, e_if_err);
    chk("mon_d_ack", d_ack, e_d_ack);
    chk("mon_d_err", d_err, e_d_err);
    chk("mon_if_rdata", if_rdata, e_if_rdata);
    chk("mon_d_rdata", d_rdata, e_d_rdata);
    chk("mon_stall", stall_o, e_stall);
    p_rst = rst; p_wait = slave_wait;
    p_if_req = if_req; p_if_addr = if_addr;
    p_d_req = d_req; p_d_we = d_we; p_d_sel = d_sel; p_d_addr = d_addr; p_d_wdata = d_wdata;
  end

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req, d_we;
    logic [3:0]  d_sel;
    logic [31:0] d_addr, d_wdata;
    int unsigned wcyc;
    logic        x_stb, x_we;
    logic [3:0]  x_sel;
    logic [31:0] x_addr, x_wdata;
    logic        x_ia, x_ie, x_da, x_de;
    logic [31:0] x_ird, x_drd;
    logic [5:0]  x_stall;
  } vec_t;

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr, dw,
                              input logic [3:0] ds, input logic [31:0] da, dwd, input int unsigned w,
                              input logic xs, xw, input logic [3:0] xsl, input logic [31:0] xa, xwd,
                              input logic xia, xie, xda, xde, input logic [31:0] xir, xdr,
                              input logic [5:0] xst);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.d_req = dr; v.d_we = dw; v.d_sel = ds; v.d_addr = da;
    v.d_wdata = dwd; v.wcyc = w; v.x_stb = xs; v.x_we = xw; v.x_sel = xsl; v.x_addr = xa;
    v.x_wdata = xwd; v.x_ia = xia; v.x_ie = xie; v.x_da = xda; v.x_de = xde;
    v.x_ird = xir; v.x_drd = xdr; v.x_stall = xst;
    return v;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  vec_t        vt[$];
  logic [31:0] dv_fix, dv100, dv0, z;
  int          n, rises, acks;
  logic        got, prev_stb, last_d_ack, last_if_ack;

  initial begin
    dv_fix = 32'h3401_1100;
    dv100  = slave_data(32'h100);
    dv0    = slave_data(32'h0);
    z      = 32'h0;
    // Fetch with zero-wait slave.
    vt.push_back(mk(H,32'h10, L,L,4'h0,z,z, 0, L,L,4'h0,z,z, L,L,L,L, z,z, 6'b000111));
    vt.push_back(mk(H,32'h10, L,L,4'h0,z,z, 0, H,L,4'hF,32'h10,z, L,L,L,L, z,z, 6'b000111));
    vt.push_back(mk(H,32'h10, L,L,4'h0,z,z, 0, L,L,4'h0,z,z, H,L,L,L, dv_fix,z, 6'b000000));
    vt.push_back(mk(L,z, L,L,4'h0,z,z, 0, L,L,4'h0,z,z, L,L,L,L, dv_fix,z, 6'b000000));
    // Simultaneous load and fetch, one wait state each: data first.
    vt.push_back(mk(H,z, H,L,4'hF,32'h100,z, 1, L,L,4'h0,z,z, L,L,L,L, dv_fix,z, 6'b011111));
    vt.push_back(mk(H,z, H,L,4'hF,32'h100,z, 1, H,L,4'hF,32'h100,z, L,L,L,L, dv_fix,z, 6'b011111));
    vt.push_back(mk(H,z, H,L,4'hF,32'h100,z, 1, H,L,4'hF,32'h100,z, L,L,L,L, dv_fix,z, 6'b011111));
    vt.push_back(mk(H,z, H,L,4'hF,32'h100,z, 1, L,L,4'h0,z,z, L,L,H,L, dv_fix,dv100, 6'b000111));
    vt.push_back(mk(H,z, L,L,4'hF,32'h100,z, 1, H,L,4'hF,z,z, L,L,L,L, dv_fix,dv100, 6'b000111));
    vt.push_back(mk(H,z, L,L,4'hF,32'h100,z, 1, H,L,4'hF,z,z, L,L,L,L, dv_fix,dv100, 6'b000111));
    vt.push_back(mk(H,z, L,L,4'hF,32'h100,z, 1, L,L,4'h0,z,z, H,L,L,L, dv0,dv100, 6'b000000));
    vt.push_back(mk(L,z, L,L,4'hF,32'h100,z, 1, L,L,4'h0,z,z, L,L,L,L, dv0,dv100, 6'b000000));
    // Partial-word store: d_rdata keeps the previous load value.
    vt.push_back(mk(L,z, H,H,4'h3,32'h20,32'hDEAD_BEEF, 0, L,L,4'h0,z,z, L,L,L,L, dv0,dv100, 6'b011111));
    vt.push_back(mk(L,z, H,H,4'h3,32'h20,32'hDEAD_BEEF, 0, H,H,4'h3,32'h20,32'hDEAD_BEEF, L,L,L,L, dv0,dv100, 6'b011111));
    vt.push_back(mk(L,z, H,H,4'h3,32'h20,32'hDEAD_BEEF, 0, L,L,4'h0,z,z, L,L,H,L, dv0,dv100, 6'b000000));
    vt.push_back(mk(L,z, L,L,4'h0,z,z, 0, L,L,4'h0,z,z, L,L,L,L, dv0,dv100, 6'b000000));

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stb", bus_stb, 1'b0);
    chk("rst_addr", bus_addr, 32'h0);
    chk("rst_sel", bus_sel, 4'h0);
    chk("rst_acks", {if_ack, if_err, d_ack, d_err}, 4'h0);
    chk("rst_rdata", if_rdata | d_rdata, 32'h0);
    next_cycle();

    foreach (vt[i]) begin
      if_req = vt[i].if_req; if_addr = vt[i].if_addr;
      d_req = vt[i].d_req; d_we = vt[i].d_we; d_sel = vt[i].d_sel;
      d_addr = vt[i].d_addr; d_wdata = vt[i].d_wdata; slave_wait = vt[i].wcyc;
      @(negedge clk);
      chk($sformatf("vec%0d_stb", i), bus_stb, vt[i].x_stb);
      chk($sformatf("vec%0d_we", i), bus_we, vt[i].x_we);
      if (vt[i].x_stb) begin
        chk($sformatf("vec%0d_addr", i), bus_addr, vt[i].x_addr);
        chk($sformatf("vec%0d_sel", i), bus_sel, vt[i].x_sel);
        chk($sformatf("vec%0d_wdata", i), bus_wdata, vt[i].x_wdata);
      end
      chk($sformatf("vec%0d_acks", i), {if_ack, if_err, d_ack, d_err},
          {vt[i].x_ia, vt[i].x_ie, vt[i].x_da, vt[i].x_de});
      chk($sformatf("vec%0d_if_rdata", i), if_rdata, vt[i].x_ird);
      chk($sformatf("vec%0d_d_rdata", i), d_rdata, vt[i].x_drd);
      chk($sformatf("vec%0d_stall", i), stall_o, vt[i].x_stall);
      next_cycle();
    end

    // Timeout on a load while a fetch waits behind it.
    slave_wait = 99;
    d_req = 1; d_we = 0; d_sel = 4'hF; d_addr = 32'h40;
    if_req = 1; if_addr = 32'h80;
    n = 0; got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_stb) n++;
      if (d_ack) begin
        got = 1;
        break;
      end
      next_cycle();
    end
    chk("to_ack_seen", got, 1'b1);
    chk("to_stb_cycles", n, TO);
    chk("to_d_err", d_err, 1'b1);
    chk("to_d_rdata", d_rdata, 32'h0);
    next_cycle();
    d_req = 0; slave_wait = 0;
    @(negedge clk);
    chk("to_if_stb", bus_stb, 1'b1);
    chk("to_if_addr", bus_addr, 32'h80);
    next_cycle();
    @(negedge clk);
    chk("to_if_ack", {if_ack, if_err}, 2'b10);
    chk("to_if_rdata", if_rdata, slave_data(32'h80));
    next_cycle();
    if_req = 0;

    // Reset in the middle of a fetch grant.
    next_cycle();
    slave_wait = 99; if_req = 1; if_addr = 32'h200;
    next_cycle();
    @(negedge clk);
    chk("rstmid_stb_before", bus_stb, 1'b1);
    next_cycle();
    rst = 1;
    next_cycle();
    rst = 0; slave_wait = 0;
    @(negedge clk);
    chk("rstmid_stb", bus_stb, 1'b0);
    chk("rstmid_if_ack", if_ack, 1'b0);
    chk("rstmid_stall", stall_o, 6'b000111);
    chk("rstmid_if_rdata", if_rdata, 32'h0);
    next_cycle();
    @(negedge clk);
    chk("rstmid_new_stb", bus_stb, 1'b1);
    chk("rstmid_new_addr", bus_addr, 32'h200);
    next_cycle();
    @(negedge clk);
    chk("rstmid_new_ack", {if_ack, if_err}, 2'b10);
    chk("rstmid_new_rdata", if_rdata, slave_data(32'h200));
    next_cycle();
    if_req = 0;

    // Request held past its ack vs. dropped on ack.
    for (int k = 0; k < 2; k++) begin
      int hi;
      hi = (k == 0) ? 6 : 3;
      d_we = 0; d_sel = 4'hF; d_addr = 32'h300; slave_wait = 0;
      rises = 0; acks = 0; prev_stb = 0;
      for (int c = 0; c < 10; c++) begin
        d_req = (c < hi);
        @(negedge clk);
        if (bus_stb && !prev_stb) rises++;
        prev_stb = bus_stb;
        if (d_ack) acks++;
        next_cycle();
      end
      chk($sformatf("hold%0d_stb_rises", k), rises, (k == 0) ? 2 : 1);
      chk($sformatf("hold%0d_acks", k), acks, (k == 0) ? 2 : 1);
    end

    // Randomized traffic, checked every cycle by the model.
    last_d_ack = 0; last_if_ack = 0; acks = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if (!bus_stb) slave_wait = $urandom_range(0, 5);
      if (d_req) begin
        if (last_d_ack && $urandom_range(0, 7) != 0) d_req = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        d_req = 1; d_we = 1'($urandom); d_sel = 4'($urandom);
        d_addr = $urandom; d_wdata = $urandom;
      end
      if (if_req) begin
        if (last_if_ack && $urandom_range(0, 7) != 0) if_req = 0;
      end else if ($urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = $urandom;
      end
      @(negedge clk);
      last_d_ack = d_ack;
      last_if_ack = if_ack;
      if (d_ack || if_ack) acks++;
      next_cycle();
    end
    chk("rand_activity", (acks > 100), 1'b1);

    rst = 0; d_req = 0; if_req = 0;
    repeat (TO + 4) next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Shares one external memory bus between the instruction-fetch port (PC/IF stage) and the data port (MEM stage, load/store) of the 5-stage pipeline. It sequences single-beat transactions with a registered request/ack handshake and a wait-state timeout. It also drives the pipeline stall vector while any requester is waiting.

Parameters:
TIMEOUT, 255, max cycles bus_stb may stay high without bus_ack before the arbiter aborts (1..255).

Ports:
clk  in  1  clock; all logic rising-edge.
rst  in  1  synchronous reset, active-high.
if_req  in  1  fetch request; held until if_ack.
if_addr  in  32  fetch byte address.
if_rdata  out  32  fetched word; valid when if_ack=1.
if_ack  out  1  one-cycle completion pulse for the fetch port.
if_err  out  1  qualifies if_ack; 1 = timeout.
d_req  in  1  data request; held until d_ack.
d_we  in  1  1 = store, 0 = load.
d_sel  in  4  byte enables.
d_addr  in  32  data byte address.
d_wdata  in  32  store data.
d_rdata  out  32  load data; valid when d_ack=1.
d_ack  out  1  one-cycle completion pulse for the data port.
d_err  out  1  qualifies d_ack; 1 = timeout.
bus_stb  out  1  transaction active.
bus_we  out  1  write strobe.
bus_sel  out  4  byte enables.
bus_addr  out  32  address.
bus_wdata  out  32  write data.
bus_rdata  in  32  read data; sampled with bus_ack.
bus_ack  in  1  slave completion; ignored when bus_stb=0.
stall_o  out  6  stall bits {wb,mem,ex,id,if,pc} (bit0 = pc).

Behaviour:
- Reset: state IDLE; bus_stb, bus_we, if_ack, d_ack, if_err, d_err = 0; bus_sel = 0; bus_addr, bus_wdata, if_rdata, d_rdata = 0; timeout counter = 0. A reset mid-transaction drops bus_stb in the next cycle with no ack to either port.
- FSM states: IDLE, GRANT_D, GRANT_IF.
- Request masking: in IDLE, a port whose ack is high in the current cycle has its req masked. This prevents reissuing a request the requester is still holding.
- IDLE with unmasked d_req: go to GRANT_D. Register bus_stb=1, bus_addr=d_addr, bus_we=d_we, bus_sel=d_sel, bus_wdata=d_wdata.
- IDLE with unmasked if_req only: go to GRANT_IF. Register bus_stb=1, bus_addr=if_addr, bus_we=0, bus_sel=4'b1111. bus_wdata is unchanged.
- Priority: data port always wins on simultaneous requests (older instruction). There is no round-robin.
- Grant states, bus_stb=1 and bus_ack=1: next cycle return to IDLE with bus_stb=0, bus_we=0, granted ack=1, err=0. For a load or fetch, the rdata register captures bus_rdata. For a store, d_rdata is unchanged.
- Grant states, bus_ack=0: counter increments. When counter == TIMEOUT-1 and there is still no ack, abort. Next cycle return to IDLE with bus_stb=0, granted ack=1, err=1, rdata=0.
- Counter clears on every entry to IDLE.
- The other port's request stays pending through a grant. Its req is never dropped by the arbiter.
- Latency: request registered in cycle N; bus_stb high in N+1; with a zero-wait slave (ack in N+1), the port ack is in N+2. Back-to-back service of the other port: its bus_stb is high in N+3.
- Acks and errs are single-cycle pulses. Bus outputs are registered; there is no combinational path from req to the bus.
- stall_o is combinational:
  - d_req & ~d_ack gives 6'b011111 (pc, if, id, ex, mem).
  - else if_req & ~if_ack gives 6'b000111 (pc, if, id).
  - else 6'b000000.
- Width rules: the counter is 8 bits and never wraps, because the abort fires first.
- Requester inputs are sampled only in IDLE. Changes during a grant are ignored.

Test Plan:
- Reset, then if_req=1, if_addr=32'h0000_0010, slave acks in the same cycle as stb with bus_rdata=32'h3401_1100 -> bus_addr=32'h10 and bus_sel=4'hF in N+1; if_ack=1, if_err=0, if_rdata=32'h3401_1100 in N+2; stall_o=6'b000111 during N..N+1 and 0 in N+2.
- if_req and d_req (load, d_addr=32'h100) asserted together, both slaves acking in 2 cycles -> data is granted first with stall_o=6'b011111; fetch is granted next with bus_addr=32'h0 and stall_o=6'b000111; exactly one d_ack and one if_ack.
- Store d_we=1, d_sel=4'b0011, d_wdata=32'hDEAD_BEEF, d_addr=32'h20 -> bus_we=1, bus_sel=4'b0011, bus_wdata=32'hDEAD_BEEF; d_ack pulses once; d_rdata is unchanged.
- TIMEOUT=4, slave never acks -> bus_stb is high exactly 4 cycles, then d_ack=1, d_err=1, d_rdata=0; the FSM returns to IDLE and serves a pending if_req next.
- rst=1 asserted while in GRANT_IF with bus_stb=1 -> next cycle bus_stb=0, if_ack=0, stall_o follows inputs; a fresh if_req after reset completes normally.
- d_req held high for 3 cycles after d_ack -> the request is masked in the ack cycle only and a second transaction starts; the bench confirms the requester protocol (drop req on ack) produces exactly one bus transaction.
